// File: rtl/axi_line_arbiter.sv
// ---------------------------------------------------------------------------
// axi_line_arbiter
//
// Purpose:
//   Lets the icache refill port and the dcache refill/writeback port share one
//   cache-line AXI engine. The arbiter picks a winner when it is idle and
//   latches that requester's command (address, write line, read/write flags).
//   It then presents the latched command to the engine until the engine
//   signals completion. The completion pulse and the returned line are
//   routed back to the owner in the same cycle. One release cycle follows
//   each transaction so the owner can drop its request.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin between the two ports on a tie.
//                          A 1-bit last-owner register is used, and its
//                          reset value is icache.
//              undefined -> fixed priority: dcache wins any tie.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_rd_req, i_addr    icache line-read request (level) and line address
//   i_gnt, i_rd_line    icache completion pulse and refill data
//   d_rd_req, d_wr_req  dcache refill / writeback requests (level)
//   d_addr, d_wr_line   dcache line address and writeback data
//   d_gnt, d_rd_line    dcache completion pulse and refill data
//   m_rd_req, m_wr_req  engine read / write request (from latched regs)
//   m_addr, m_wr_line   engine address / write data (from latched regs)
//   m_gnt, m_rd_line    engine completion pulse and read data
//   busy                arbiter owns the engine (state != IDLE)
// ---------------------------------------------------------------------------
module axi_line_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    // icache port
    input  logic                     i_rd_req,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     i_gnt,
    output logic [LINE_WORDS*32-1:0] i_rd_line,
    // dcache port
    input  logic                     d_rd_req,
    input  logic                     d_wr_req,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [LINE_WORDS*32-1:0] d_wr_line,
    output logic                     d_gnt,
    output logic [LINE_WORDS*32-1:0] d_rd_line,
    // engine port
    output logic                     m_rd_req,
    output logic                     m_wr_req,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [LINE_WORDS*32-1:0] m_wr_line,
    input  logic                     m_gnt,
    input  logic [LINE_WORDS*32-1:0] m_rd_line,
    // status
    output logic                     busy
);

    localparam int LINE_W = LINE_WORDS * 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LINE_W-1:0]   wr_line_reg;
    logic                rd_req_reg;
    logic                wr_req_reg;

    logic                d_any;
    logic                pick_d;

    assign d_any = d_rd_req | d_wr_req;

`ifdef ARB_RR_EN
    // 1 = dcache won the most recent arbitration, 0 = icache.
    logic last_d_reg;

    // On a tie, the port that did not win last time goes first.
    always_comb begin
        pick_d = d_any && (!i_rd_req || !last_d_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (pick_d) begin
                last_d_reg <= 1'b1;
            end else if (i_rd_req) begin
                last_d_reg <= 1'b0;
            end
        end
    end
`else
    // The memory stage must not starve behind instruction fetch.
    always_comb begin
        pick_d = d_any;
    end
`endif

    // Main FSM. The engine command is only loaded on the IDLE -> OWN_x step,
    // so m_* stays stable for the whole transaction even if the requester
    // changes its inputs or drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wr_line_reg <= '0;
            rd_req_reg  <= 1'b0;
            wr_req_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_d) begin
                        state_reg   <= OWN_D;
                        addr_reg    <= d_addr;
                        wr_line_reg <= d_wr_line;
                        rd_req_reg  <= d_rd_req;
                        wr_req_reg  <= d_wr_req;
                    end else if (i_rd_req) begin
                        state_reg   <= OWN_I;
                        addr_reg    <= i_addr;
                        wr_line_reg <= '0;
                        rd_req_reg  <= 1'b1;
                        wr_req_reg  <= 1'b0;
                    end
                end
                OWN_I, OWN_D: begin
                    // The engine cannot abort, so only its completion ends ownership.
                    if (m_gnt) begin
                        state_reg  <= REL;
                        rd_req_reg <= 1'b0;
                        wr_req_reg <= 1'b0;
                    end
                end
                REL: begin
                    // Gives the owner one cycle to drop its level request
                    // before arbitration runs again.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_rd_req  = rd_req_reg;
    assign m_wr_req  = wr_req_reg;
    assign m_addr    = addr_reg;
    assign m_wr_line = wr_line_reg;
    assign busy      = (state_reg != IDLE);

    // The completion pulse passes through in the same cycle, qualified by
    // ownership. An m_gnt seen in IDLE or REL is dropped.
    assign i_gnt = (state_reg == OWN_I) && m_gnt;
    assign d_gnt = (state_reg == OWN_D) && m_gnt;

    // Line data reaches only the owner, and only during its completion
    // cycle. Otherwise the port reads zero.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_route
        assign i_rd_line[gi*32 +: 32] = i_gnt ? m_rd_line[gi*32 +: 32] : 32'h0;
        assign d_rd_line[gi*32 +: 32] = d_gnt ? m_rd_line[gi*32 +: 32] : 32'h0;
    end

endmodule
